// File: rtl/pe_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : pe_dot_acc
//  Purpose  : Signed dot-product processing element. Computes
//             sum(a[i]*b[i]) for i = 0..N-1 at LANES products per cycle
//             under a start/busy/done handshake. The accumulator saturates
//             to the OW-bit signed range. It can optionally seed from the
//             previous result so that tiles can be chained.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous reset, active-high
//             start    - begin operation (sampled only while idle)
//             accum    - sampled with start: 1 = seed with result, 0 = seed 0
//             a_flat   - N signed AW-bit elements, a[i] = a_flat[i*AW +: AW]
//             b_flat   - N signed BW-bit elements, b[i] = b_flat[i*BW +: BW]
//             busy     - operation in progress
//             done     - one-cycle pulse when result/overflow are updated
//             result   - signed dot product, held until the next completion
//             overflow - saturation occurred during the last operation
//  Revision : 1.0 - initial release
// ============================================================================
module pe_dot_acc #(
    parameter int N     = 64,
    parameter int AW    = 16,
    parameter int BW    = 32,
    parameter int LANES = 1,
    parameter int OW    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              accum,
    input  logic [N*AW-1:0]   a_flat,
    input  logic [N*BW-1:0]   b_flat,
    output logic              busy,
    output logic              done,
    output logic [OW-1:0]     result,
    output logic              overflow
);

    localparam int c_STEPS = N / LANES;
    localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    // Lossless lane-sum width.
    localparam int c_SW    = AW + BW + $clog2(LANES);
    // Add width: one bit above both the accumulator and the lane sum, so the
    // range check is exact even when the lane sum is wider than OW.
    localparam int c_EW    = (OW > c_SW) ? OW + 1 : c_SW + 1;

    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_STEPS - 1);
    localparam logic [OW-1:0]   c_MAX  = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]   c_MIN  = {1'b1, {(OW-1){1'b0}}};

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [N*AW-1:0]   r_a;
    logic [N*BW-1:0]   r_b;
    logic [OW-1:0]     r_acc;
    logic              r_sat;
    logic [c_CW-1:0]   r_cnt;
    logic              w_load;
    logic              w_last;

    // ------------------------------------------------------------------
    // Lane products. Operand registers shift down by LANES elements every
    // RUN cycle, so the lanes always read the lowest LANES elements and no
    // wide index multiplexer is needed.
    // ------------------------------------------------------------------
    logic signed [c_SW-1:0] w_prod [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [c_SW-1:0] w_ax;
        logic signed [c_SW-1:0] w_bx;
        assign w_ax     = {{(c_SW-AW){r_a[k*AW+AW-1]}}, r_a[k*AW +: AW]};
        assign w_bx     = {{(c_SW-BW){r_b[k*BW+BW-1]}}, r_b[k*BW +: BW]};
        assign w_prod[k] = w_ax * w_bx;
    end

    logic signed [c_SW-1:0] w_lsum;
    always_comb begin
        w_lsum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lsum = w_lsum + w_prod[k];
        end
    end

    // ------------------------------------------------------------------
    // Saturating accumulate
    // ------------------------------------------------------------------
    logic [c_EW-1:0]   w_sum;
    logic [c_EW-OW:0]  w_hi;
    logic              w_clamp;
    logic [OW-1:0]     w_acc_nxt;

    always_comb begin
        w_sum = {{(c_EW-OW){r_acc[OW-1]}}, r_acc}
              + {{(c_EW-c_SW){w_lsum[c_SW-1]}}, w_lsum};
        // The value fits in OW bits only when every bit from OW-1 upward
        // matches the sign.
        w_hi      = w_sum[c_EW-1:OW-1];
        w_clamp   = !((&w_hi) || !(|w_hi));
        w_acc_nxt = w_clamp ? (w_sum[c_EW-1] ? c_MIN : c_MAX) : w_sum[OW-1:0];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (r_state == c_RUN);
        w_load = (r_state == c_IDLE) && start;
        w_last = (r_state == c_RUN) && (r_cnt == c_LAST);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_cnt    <= '0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                r_a   <= a_flat;
                r_b   <= b_flat;
                // result is already updated in the done cycle, so a
                // back-to-back chained start seeds with the fresh value.
                r_acc <= accum ? result : '0;
                r_sat <= 1'b0;
                r_cnt <= '0;
            end else if (busy) begin
                r_a   <= r_a >> (LANES*AW);
                r_b   <= r_b >> (LANES*BW);
                r_acc <= w_acc_nxt;
                r_sat <= r_sat | w_clamp;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    result   <= w_acc_nxt;
                    overflow <= r_sat | w_clamp;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_dot_acc
//  Purpose  : Directed self-checking bench for pe_dot_acc. Instance u_dut1
//             uses defaults (LANES=1, OW=64). Instance u_dut4 uses LANES=4
//             and OW=48.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_dot_acc;

    localparam longint c_MAX48 = 64'sd140737488355327;
    localparam longint c_MIN48 = -64'sd140737488355328;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           start1, accum1, busy1, done1, ovf1;
    logic [1023:0]  a1;
    logic [2047:0]  b1;
    logic [63:0]    res1;

    logic           start4, accum4, busy4, done4, ovf4;
    logic [1023:0]  a4;
    logic [2047:0]  b4;
    logic [47:0]    res4;

    pe_dot_acc u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .accum(accum1),
        .a_flat(a1), .b_flat(b1), .busy(busy1), .done(done1),
        .result(res1), .overflow(ovf1)
    );

    pe_dot_acc #(.N(64), .AW(16), .BW(32), .LANES(4), .OW(48)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .accum(accum4),
        .a_flat(a4), .b_flat(b4), .busy(busy4), .done(done4),
        .result(res4), .overflow(ovf4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Latency is counted in rising edges after the
    // edge that samples start. The task returns at the negedge on which
    // done is seen, or when the cycle budget runs out.
    task automatic run(input int which, input logic acc, input bit disturb,
                       output int lat, output int bcnt, output logic [63:0] mid);
        if (which == 1) begin start1 = 1'b1; accum1 = acc; end
        else            begin start4 = 1'b1; accum4 = acc; end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        lat  = 0;
        bcnt = 0;
        mid  = '0;
        while (((which == 1) ? !done1 : !done4) && lat < 200) begin
            if ((which == 1) ? busy1 : busy4) bcnt++;
            if (lat == 10) mid = (which == 1) ? res1 : {16'h0, res4};
            if (disturb && lat == 3) begin
                start1 = 1'b1;
                accum1 = ~acc;
                a1 = {64{16'sd2}};
                b1 = {64{32'sd5}};
            end
            if (disturb && lat == 4) start1 = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ramp(input int which);
        for (int i = 0; i < 64; i++) begin
            if (which == 1) begin a1[i*16 +: 16] = 16'd1; b1[i*32 +: 32] = 32'(i); end
            else            begin a4[i*16 +: 16] = 16'd1; b4[i*32 +: 32] = 32'(i); end
        end
    endtask

    // Reference model for the LANES=4, OW=48 instance: saturation is
    // applied after each four-product step.
    task automatic model4(input logic [1023:0] a, input logic [2047:0] b,
                          input longint seed, output longint r, output bit o);
        longint ls;
        r = seed;
        o = 1'b0;
        for (int s = 0; s < 16; s++) begin
            ls = 0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = s*4 + k;
                ls += longint'($signed(a[idx*16 +: 16])) * longint'($signed(b[idx*32 +: 32]));
            end
            r += ls;
            if (r > c_MAX48)      begin r = c_MAX48; o = 1'b1; end
            else if (r < c_MIN48) begin r = c_MIN48; o = 1'b1; end
        end
    endtask

    initial begin
        int lat, bc, seen;
        logic [63:0] mid;
        longint prev, er;
        bit eo;
        logic acc;

        rst = 1'b1;
        start1 = 1'b0; accum1 = 1'b0; start4 = 1'b0; accum4 = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_res1",  res1,       64'd0);
        chk("rst_ovf1",  64'(ovf1),  64'd0);
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_res4",  {16'h0, res4}, 64'd0);

        // 1: ramp dot product, 64-cycle latency
        ramp(1);
        run(1, 1'b0, 1'b0, lat, bc, mid);
        chk("t1_lat",  64'(lat),   64'd64);
        chk("t1_busy", 64'(bc),    64'd64);
        chk("t1_res",  res1,       64'd2016);
        chk("t1_ovf",  64'(ovf1),  64'd0);
        chk("t1_bsy0", 64'(busy1), 64'd0);

        // 2: back-to-back start in the done cycle, chained accumulate
        run(1, 1'b1, 1'b0, lat, bc, mid);
        chk("t2_lat",  64'(lat), 64'd64);
        chk("t2_mid",  mid,      64'd2016);
        chk("t2_res",  res1,     64'd4032);
        @(negedge clk);
        chk("t2_pulse", 64'(done1), 64'd0);

        // 4: reset ten cycles into a run
        start1 = 1'b1; accum1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_busy", 64'(busy1), 64'd0);
        chk("t4_res",  res1,       64'd0);
        chk("t4_ovf",  64'(ovf1),  64'd0);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done1) seen++;
        end
        chk("t4_nodone", 64'(seen), 64'd0);
        run(1, 1'b0, 1'b0, lat, bc, mid);
        chk("t4_lat", 64'(lat), 64'd64);
        chk("t4_res2", res1,    64'd2016);

        // 5: start while busy and operand changes mid-run are ignored
        @(negedge clk);
        run(1, 1'b0, 1'b1, lat, bc, mid);
        chk("t5_lat", 64'(lat), 64'd64);
        chk("t5_mid", mid,      64'd2016);
        chk("t5_res", res1,     64'd2016);

        // 3: OW=48 positive saturation, then clean run clears overflow
        a4 = {64{16'h8000}};
        b4 = {64{32'h8000_0000}};
        run(4, 1'b0, 1'b0, lat, bc, mid);
        chk("t3_lat", 64'(lat),       64'd16);
        chk("t3_res", {16'h0, res4},  64'h0000_7FFF_FFFF_FFFF);
        chk("t3_ovf", 64'(ovf4),      64'd1);
        @(negedge clk);
        ramp(4);
        run(4, 1'b0, 1'b0, lat, bc, mid);
        chk("t3_res2", {16'h0, res4}, 64'd2016);
        chk("t3_ovf2", 64'(ovf4),     64'd0);
        chk("t3_mid",  mid,           64'h0000_7FFF_FFFF_FFFF);
        // Negative saturation
        @(negedge clk);
        a4 = {64{16'h8000}};
        b4 = {64{32'h7FFF_FFFF}};
        run(4, 1'b0, 1'b0, lat, bc, mid);
        chk("t3_nres", {16'h0, res4}, 64'h0000_8000_0000_0000);
        chk("t3_novf", 64'(ovf4),     64'd1);
        prev = c_MIN48;

        // 6: LANES=4 random vectors with extremes against the model
        for (int v = 0; v < 200; v++) begin
            @(negedge clk);
            for (int i = 0; i < 64; i++) begin
                case ($urandom_range(0, 3))
                    0:       a4[i*16 +: 16] = 16'h8000;
                    1:       a4[i*16 +: 16] = 16'h7FFF;
                    default: a4[i*16 +: 16] = 16'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0:       b4[i*32 +: 32] = 32'h8000_0000;
                    1:       b4[i*32 +: 32] = 32'h7FFF_FFFF;
                    default: b4[i*32 +: 32] = $urandom;
                endcase
            end
            acc = 1'($urandom_range(0, 1));
            model4(a4, b4, acc ? prev : 64'sd0, er, eo);
            run(4, acc, 1'b0, lat, bc, mid);
            chk("t6_lat", 64'(lat),      64'd16);
            chk("t6_res", {16'h0, res4}, {16'h0, er[47:0]});
            chk("t6_ovf", 64'(ovf4),     64'(eo));
            prev = er;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
